// File: rtl/cmd_issuer.sv
// Host-side command issuer for the n-bit CPU core: takes one request at a time, drives the core for LATENCY cycles and returns the result.
// Optional error stop is enabled by defining CMD_ISSUER_ERR_STOP_EN.
`timescale 1ns/1ps

module cmd_issuer #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [6:0]         req_cmd,
    input  logic [WIDTH-1:0]   req_op1,
    input  logic [WIDTH-1:0]   req_op2,
    input  logic [WIDTH-1:0]   req_op3,
    output logic [6:0]         cpu_cmd,
    output logic [WIDTH-1:0]   cpu_din_1,
    output logic [WIDTH-1:0]   cpu_din_2,
    output logic [WIDTH-1:0]   cpu_din_3,
    input  logic [WIDTH-1:0]   cpu_dout_low,
    input  logic [WIDTH-1:0]   cpu_dout_high,
    input  logic               cpu_zero,
    input  logic               cpu_error,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_data,
    output logic               rsp_zero,
    output logic               rsp_error,
    output logic               busy,
    output logic [7:0]         err_count,
    output logic               halted,
    input  logic               clr_halt
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic          capture;

    assign capture   = (state == DRIVE) && (hold_cnt == '0);
    assign req_ready = (state == IDLE) && !halted;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

`ifndef CMD_ISSUER_ERR_STOP_EN
    logic unused_clr_halt;
    assign unused_clr_halt = clr_halt;
    assign halted          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            cpu_cmd   <= 7'h00;
            cpu_din_1 <= '0;
            cpu_din_2 <= '0;
            cpu_din_3 <= '0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_error <= 1'b0;
            err_count <= 8'h00;
`ifdef CMD_ISSUER_ERR_STOP_EN
            halted    <= 1'b0;
`endif
        end else begin
`ifdef CMD_ISSUER_ERR_STOP_EN
            // A fresh error capture takes priority over a simultaneous clear.
            if (capture && cpu_error) begin
                halted <= 1'b1;
            end else if (clr_halt) begin
                halted <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        cpu_cmd   <= req_cmd;
                        cpu_din_1 <= req_op1;
                        cpu_din_2 <= req_op2;
                        cpu_din_3 <= req_op3;
                        hold_cnt  <= CW'(LATENCY - 1);
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Operands stay on cpu_din after the command drops back to NOP.
                    if (capture) begin
                        rsp_data  <= {cpu_dout_high, cpu_dout_low};
                        rsp_zero  <= cpu_zero;
                        rsp_error <= cpu_error;
                        cpu_cmd   <= 7'h00;
                        if (cpu_error && (err_count != 8'hFF)) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= RESP;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed self-checking bench for cmd_issuer (LATENCY=4 main instance, LATENCY=1 instance for back-to-back timing).
// Expectations for halted follow CMD_ISSUER_ERR_STOP_EN when it is defined.
`timescale 1ns/1ps

module tb_cmd_issuer;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [6:0]  req_cmd;
    logic [7:0]  req_op1, req_op2, req_op3;
    logic [6:0]  cpu_cmd;
    logic [7:0]  cpu_din_1, cpu_din_2, cpu_din_3;
    logic [7:0]  cpu_dout_low, cpu_dout_high;
    logic        cpu_zero, cpu_error;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero, rsp_error;
    logic        busy;
    logic [7:0]  err_count;
    logic        halted, clr_halt;

    logic        b_req_valid, b_req_ready;
    logic [6:0]  b_req_cmd;
    logic [7:0]  b_req_op1, b_req_op2, b_req_op3;
    logic [6:0]  b_cpu_cmd;
    logic [7:0]  b_cpu_din_1, b_cpu_din_2, b_cpu_din_3;
    logic [7:0]  b_cpu_dout_low, b_cpu_dout_high;
    logic        b_cpu_zero, b_cpu_error;
    logic        b_rsp_valid, b_rsp_ready;
    logic [15:0] b_rsp_data;
    logic        b_rsp_zero, b_rsp_error;
    logic        b_busy;
    logic [7:0]  b_err_count;
    logic        b_halted, b_clr_halt;

    int checks = 0;
    int errors = 0;

    cmd_issuer #(.WIDTH(8), .LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_op1(req_op1), .req_op2(req_op2), .req_op3(req_op3),
        .cpu_cmd(cpu_cmd), .cpu_din_1(cpu_din_1), .cpu_din_2(cpu_din_2), .cpu_din_3(cpu_din_3),
        .cpu_dout_low(cpu_dout_low), .cpu_dout_high(cpu_dout_high),
        .cpu_zero(cpu_zero), .cpu_error(cpu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_error(rsp_error),
        .busy(busy), .err_count(err_count), .halted(halted), .clr_halt(clr_halt)
    );

    cmd_issuer #(.WIDTH(8), .LATENCY(1)) dut_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_cmd(b_req_cmd),
        .req_op1(b_req_op1), .req_op2(b_req_op2), .req_op3(b_req_op3),
        .cpu_cmd(b_cpu_cmd), .cpu_din_1(b_cpu_din_1), .cpu_din_2(b_cpu_din_2), .cpu_din_3(b_cpu_din_3),
        .cpu_dout_low(b_cpu_dout_low), .cpu_dout_high(b_cpu_dout_high),
        .cpu_zero(b_cpu_zero), .cpu_error(b_cpu_error),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_zero(b_rsp_zero), .rsp_error(b_rsp_error),
        .busy(b_busy), .err_count(b_err_count), .halted(b_halted), .clr_halt(b_clr_halt)
    );

    // Core stub: low = din_1 + din_2, high = din_3, command 7'h7F reports an error.
    assign cpu_dout_low    = cpu_din_1 + cpu_din_2;
    assign cpu_dout_high   = cpu_din_3;
    assign cpu_zero        = ({cpu_dout_high, cpu_dout_low} == 16'h0000);
    assign cpu_error       = (cpu_cmd == 7'h7F);
    assign b_cpu_dout_low  = b_cpu_din_1 + b_cpu_din_2;
    assign b_cpu_dout_high = b_cpu_din_3;
    assign b_cpu_zero      = ({b_cpu_dout_high, b_cpu_dout_low} == 16'h0000);
    assign b_cpu_error     = (b_cpu_cmd == 7'h7F);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] cmd, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_op1   = a;
        req_op2   = b;
        req_op3   = c;
    endtask

    // Full transaction with rsp_ready=1; returns in the first cycle after the response handshake.
    task automatic runCommand(input logic [6:0] cmd, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              output logic [15:0] data, output logic zero, output logic err);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        checkOutput("req_ready_wait", req_ready, 1);
        applyStimulus(cmd, a, b, c);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        checkOutput("rsp_wait", rsp_valid, 1);
        data = rsp_data;
        zero = rsp_zero;
        err  = rsp_error;
        tick();
    endtask

    logic [15:0] d;
    logic        z, e;

    initial begin
        int n;
        rst = 1'b0; clr_halt = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0; req_op3 = '0;
        b_req_valid = 1'b0; b_req_cmd = '0; b_req_op1 = '0; b_req_op2 = '0; b_req_op3 = '0;
        b_rsp_ready = 1'b1; b_clr_halt = 1'b0;
        #1;
        checkOutput("rst_cpu_cmd", cpu_cmd, 0);
        checkOutput("rst_cpu_din", {cpu_din_1, cpu_din_2, cpu_din_3}, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp", {rsp_data, rsp_zero, rsp_error}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_halted", halted, 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        $display("[TB] single command");
        checkOutput("single_ready", req_ready, 1);
        applyStimulus(7'h11, 8'd3, 8'd5, 8'd0);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("single_cmd_k+%0d", i), cpu_cmd, 7'h11);
            checkOutput($sformatf("single_nvalid_k+%0d", i), rsp_valid, 0);
            checkOutput($sformatf("single_nready_k+%0d", i), req_ready, 0);
            tick();
        end
        checkOutput("single_rsp_valid", rsp_valid, 1);
        checkOutput("single_rsp_data", rsp_data, 16'h0008);
        checkOutput("single_rsp_zero", rsp_zero, 0);
        checkOutput("single_cmd_nop", cpu_cmd, 7'h00);
        tick();
        checkOutput("single_ready_after", req_ready, 1);
        checkOutput("single_idle", busy, 0);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(7'h22, 8'd10, 8'd20, 8'h5A);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        checkOutput("bp_rsp_arrive", rsp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_data", rsp_data, 16'h5A1E);
            checkOutput("bp_flags", {rsp_zero, rsp_error}, 2'b00);
            checkOutput("bp_ready", req_ready, 0);
            checkOutput("bp_cmd", cpu_cmd, 7'h00);
            checkOutput("bp_busy", busy, 1);
            checkOutput("bp_valid", rsp_valid, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_idle_busy", busy, 0);
        checkOutput("bp_idle_ready", req_ready, 1);

        $display("[TB] zero flag");
        runCommand(7'h33, 8'd0, 8'd0, 8'd0, d, z, e);
        checkOutput("zero_data", d, 16'h0000);
        checkOutput("zero_flag", z, 1);
        checkOutput("zero_err", e, 0);
        checkOutput("zero_err_count", err_count, 0);

        $display("[TB] error stop");
        runCommand(7'h7F, 8'd1, 8'd1, 8'd0, d, z, e);
        checkOutput("estop_data", d, 16'h0002);
        checkOutput("estop_err", e, 1);
        checkOutput("estop_err_count", err_count, 1);
`ifdef CMD_ISSUER_ERR_STOP_EN
        checkOutput("estop_halted", halted, 1);
        checkOutput("estop_ready", req_ready, 0);
        clr_halt = 1'b1;
        tick();
        clr_halt = 1'b0;
        checkOutput("estop_cleared", halted, 0);
        checkOutput("estop_ready_after", req_ready, 1);
`else
        checkOutput("estop_halted", halted, 0);
        checkOutput("estop_ready", req_ready, 1);
`endif
        runCommand(7'h12, 8'd7, 8'd1, 8'd0, d, z, e);
        checkOutput("estop_next_data", d, 16'h0008);

        $display("[TB] reset mid-drive");
        applyStimulus(7'h55, 8'd1, 8'd1, 8'd1);
        tick();
        req_valid = 1'b0;
        tick();
        checkOutput("mid_cmd_before", cpu_cmd, 7'h55);
        rst = 1'b0;
        #1;
        checkOutput("mid_cmd_reset", cpu_cmd, 7'h00);
        checkOutput("mid_valid_reset", rsp_valid, 0);
        checkOutput("mid_busy_reset", busy, 0);
        checkOutput("mid_err_count_reset", err_count, 0);
        applyStimulus(7'h66, 8'd9, 8'd9, 8'd9);
        tick(); tick();
        req_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("mid_no_rsp", rsp_valid, 0);
            checkOutput("mid_no_busy", busy, 0);
            tick();
        end
        runCommand(7'h56, 8'd2, 8'd3, 8'd0, d, z, e);
        checkOutput("mid_new_data", d, 16'h0005);

        $display("[TB] back-to-back latency 1");
        b_req_valid = 1'b1; b_req_cmd = 7'h41; b_req_op1 = 8'd1; b_req_op2 = 8'd2; b_req_op3 = 8'd0;
        checkOutput("b2b_ready_a", b_req_ready, 1);
        tick();
        b_req_cmd = 7'h42; b_req_op1 = 8'd4; b_req_op2 = 8'd4;
        checkOutput("b2b_cmd_a", b_cpu_cmd, 7'h41);
        checkOutput("b2b_nready_drive", b_req_ready, 0);
        tick();
        checkOutput("b2b_rsp_a", b_rsp_valid, 1);
        checkOutput("b2b_data_a", b_rsp_data, 16'h0003);
        checkOutput("b2b_nop_resp", b_cpu_cmd, 7'h00);
        checkOutput("b2b_nready_resp", b_req_ready, 0);
        tick();
        checkOutput("b2b_ready_r+1", b_req_ready, 1);
        checkOutput("b2b_nop_r+1", b_cpu_cmd, 7'h00);
        checkOutput("b2b_nvalid_r+1", b_rsp_valid, 0);
        tick();
        b_req_valid = 1'b0;
        checkOutput("b2b_cmd_b", b_cpu_cmd, 7'h42);
        tick();
        checkOutput("b2b_rsp_b", b_rsp_valid, 1);
        checkOutput("b2b_data_b", b_rsp_data, 16'h0008);
        tick();
        checkOutput("b2b_idle", b_busy, 0);

        $display("[TB] error saturation");
        clr_halt = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            runCommand(7'h7F, 8'd1, 8'd0, 8'd0, d, z, e);
            if (i == 1 || i == 254 || i == 255) begin
                checkOutput($sformatf("sat_count_%0d", i), err_count, i);
            end
        end
        clr_halt = 1'b0;
        checkOutput("sat_hold", err_count, 8'hFF);
        tick(); tick();
        checkOutput("sat_hold_idle", err_count, 8'hFF);
        rst = 1'b0;
        #1;
        checkOutput("sat_reset", err_count, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("sat_after_reset", err_count, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
# cmd_issuer

Host-side command initiator for the n-bit CPU core. Accepts one command plus three operands at a time over a valid/ready request port, drives them onto the core's command and data inputs, holds them for a fixed LATENCY, captures the core's result and flags, and returns them over a valid/ready response port. It also keeps a saturating count of error responses. The block sits between a test/host controller and the CPU's `cmdin`, `din_1..3`, `dout_low/high`, `zero` and `error` pins.

## Interface
- WIDTH, 8: CPU datapath width in bits.
- LATENCY, 4: cycles the command is held on the core before the result is sampled; legal range is 1 and up.

- clk  input  1  sole clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_cmd  input  7  command word for the core.
- req_op1, req_op2, req_op3  input  WIDTH  operands; req_op1 is also the memory address.
- cpu_cmd  output  7  drives core `cmdin`.
- cpu_din_1, cpu_din_2, cpu_din_3  output  WIDTH  drive core `din_1..3`.
- cpu_dout_low, cpu_dout_high  input  WIDTH  core result.
- cpu_zero, cpu_error  input  1  core flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  host accepts the response.
- rsp_data  output  2*WIDTH  {cpu_dout_high, cpu_dout_low} as captured.
- rsp_zero, rsp_error  output  1  captured flags.
- busy  output  1  a command is in flight or a response is pending.
- err_count  output  8  saturating count of responses with rsp_error=1.
- halted  output  1  error stop active (see Configuration).
- clr_halt  input  1  single-cycle pulse that clears halted.

## Operation
State machine states: IDLE, DRIVE, RESP.

- **IDLE**
  - req_ready = !halted.
  - On a req_valid & req_ready edge: latch req_cmd and req_op1..3, load the hold counter with LATENCY-1, go to DRIVE.
- **DRIVE**
  - cpu_cmd = latched command; cpu_din_1..3 = latched operands.
  - The counter decrements each cycle.
  - On the edge where the counter equals 0:
    - capture cpu_dout_high/low, cpu_zero and cpu_error into the rsp_* registers;
    - increment err_count if cpu_error=1;
    - go to RESP.
- **RESP**
  - rsp_valid=1; rsp_* are stable until the handshake.
  - On a rsp_valid & rsp_ready edge: go to IDLE.
- **Outputs outside DRIVE**
  - cpu_cmd = 7'h00 (NOP).
  - cpu_din_1..3 keep their last latched values.
- busy = (state != IDLE).
- req_ready=0 in DRIVE and RESP. Requests are never accepted in the same cycle as a response handshake.
- err_count saturates at 8'hFF and does not wrap. It is cleared only by reset.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, and all of the following are 0:
  - cpu_cmd, cpu_din_1..3;
  - rsp_valid, rsp_data, rsp_zero, rsp_error;
  - busy, err_count, halted.
- req_valid is ignored while rst=0.
- Acceptance at edge k:
  - cpu_cmd is valid in cycles k+1 to k+LATENCY inclusive;
  - sampling happens at the edge ending cycle k+LATENCY;
  - rsp_valid=1 from cycle k+LATENCY+1.
- LATENCY=1: the command is driven for exactly one cycle.
- After the response handshake at edge r, req_ready=1 in cycle r+1. The minimum command-to-command spacing is therefore LATENCY+2 cycles.
- Reset mid-DRIVE or mid-RESP: the in-flight command and the pending response are discarded, and cpu_cmd returns to 0 immediately.
- rsp_ready held high in IDLE or DRIVE has no effect.

## Configuration
Macro: `CMD_ISSUER_ERR_STOP_EN`.

- **Defined:**
  - A captured cpu_error=1 sets halted at the capture edge.
  - While halted=1, req_ready=0. The pending response still completes normally.
  - A clr_halt pulse clears halted on the next edge.
  - If clr_halt coincides with a new error capture, the capture wins and halted stays 1.
- **Undefined:**
  - halted is tied to 0 and clr_halt is ignored.
  - Errors only increment err_count.

## Test plan
The bench uses a core stub that drives cpu_dout from cpu_cmd/cpu_din with fixed values.

- **Single command:** LATENCY=4, req_cmd=7'h11, op1=3, op2=5, stub returns 16'h0008, zero=0, rsp_ready=1.
  - cpu_cmd=7'h11 in cycles k+1..k+4.
  - rsp_valid at k+5 with rsp_data=16'h0008.
  - req_ready=1 at k+6.
- **Backpressure:** rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_data, rsp_zero and rsp_error are stable; req_ready=0; cpu_cmd=7'h00; busy=1.
  - Handshake on cycle 11, then IDLE.
- **Error saturation:** 260 commands with stub cpu_error=1.
  - err_count=255 and holds.
  - Followed by reset: err_count=0.
- **Reset mid-DRIVE:** assert rst=0 in cycle k+2 of a LATENCY=4 command.
  - cpu_cmd=0 and rsp_valid=0 immediately.
  - After release, no response appears and a new request is accepted.
- **Error stop (macro defined):** one error response.
  - halted=1 and req_ready=0 after the handshake.
  - A clr_halt pulse gives req_ready=1 on the next cycle.
  - With the macro undefined, the same stimulus gives halted=0 and the next request is accepted.
- **Back-to-back, LATENCY=1:** two queued requests.
  - The second is accepted at r+1 after the first handshake.
  - cpu_cmd is 7'h00 between the two commands.
